// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding and constants for the MII transmit path
package eth_pkg;
    typedef enum logic [2:0] {IDLE, LO, HI, ERR, DRAIN, IFG} state_t;
    localparam int ETH_DEFAULT_IFG_OCTETS = 12;
    localparam int MII_NIBBLE_W = 4;
endpackage

// File: rtl/eth_mii_tx.sv
// eth_mii_tx: serialises framed AXI Stream bytes onto MII TX with inter-frame gap and underrun handling
module eth_mii_tx
    import eth_pkg::*;
#(
    parameter int IFG_OCTETS = ETH_DEFAULT_IFG_OCTETS
) (
    input  logic                    clk,
    input  logic                    aresetn,
    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [7:0]              axis_i_tdata,
    output logic                    mii_tx_en,
    output logic                    mii_tx_er,
    output logic [MII_NIBBLE_W-1:0] mii_txd,
    output logic                    frame_done,
    output logic                    underrun
);
    localparam int CW = $clog2(2 * IFG_OCTETS);
    localparam logic [CW-1:0] IFG_LOAD = CW'(2 * IFG_OCTETS - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [7:0]              byte_q, byte_d;
    logic                    last_q, last_d;
    logic                    tready_q, tready_d;
    logic                    tx_en_q, tx_en_d;
    logic                    tx_er_q, tx_er_d;
    logic [MII_NIBBLE_W-1:0] txd_q, txd_d;
    logic                    frame_done_q, frame_done_d;
    logic                    underrun_q, underrun_d;
    logic                    accept;

    assign accept        = tready_q & axis_i_tvalid;
    assign axis_i_tready = tready_q;
    assign mii_tx_en     = tx_en_q;
    assign mii_tx_er     = tx_er_q;
    assign mii_txd       = txd_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;

    // Next state, shared gap/error counter, byte capture, and outputs derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (accept) begin
                byte_d  = axis_i_tdata;
                last_d  = axis_i_tlast;
                state_d = LO;
            end
            LO: state_d = HI;
            HI: if (last_q) begin
                state_d = IFG;
                cnt_d   = IFG_LOAD;
            end else if (accept) begin
                byte_d  = axis_i_tdata;
                last_d  = axis_i_tlast;
                state_d = LO;
            end else begin
                state_d = ERR;
                cnt_d   = CW'(1);
            end
            ERR: if (cnt_q == '0) state_d = DRAIN;
                 else cnt_d = cnt_q - 1'b1;
            DRAIN: if (accept && axis_i_tlast) begin
                state_d = IFG;
                cnt_d   = IFG_LOAD;
            end
            IFG: if (cnt_q == '0) state_d = IDLE;
                 else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        tready_d     = (state_d == IDLE) || (state_d == DRAIN) || (state_d == HI && !last_d);
        tx_en_d      = (state_d == LO) || (state_d == HI) || (state_d == ERR);
        tx_er_d      = state_d == ERR;
        txd_d        = state_d == LO ? byte_d[3:0] : state_d == HI ? byte_d[7:4] : '0;
        frame_done_d = state_q == HI && last_q;
        underrun_d   = state_q == HI && !last_q && !axis_i_tvalid;
    end

    // State and registered outputs; reset truncates any frame silently
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            tready_q     <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            txd_q        <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            tready_q     <= tready_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            txd_q        <= txd_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end
endmodule

// File: tb/tb_eth_mii_tx.sv
// tb_eth_mii_tx: directed vector bench for eth_mii_tx at IFG 12 and IFG 1
module tb_eth_mii_tx;
    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       tr_a, tv_a, tl_a, en_a, er_a, fd_a, un_a;
    logic [7:0] td_a;
    logic [3:0] txd_a;
    logic       tr_b, tv_b, tl_b, en_b, er_b, fd_b, un_b;
    logic [7:0] td_b;
    logic [3:0] txd_b;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        bit         sel;
        bit         tv;
        bit         tl;
        logic [7:0] td;
        logic [8:0] exp;
        string      nm;
    } vec_t;
    vec_t rows[$];

    eth_mii_tx #(.IFG_OCTETS(12)) dut_a (
        .clk(clk), .aresetn(aresetn),
        .axis_i_tready(tr_a), .axis_i_tvalid(tv_a), .axis_i_tlast(tl_a), .axis_i_tdata(td_a),
        .mii_tx_en(en_a), .mii_tx_er(er_a), .mii_txd(txd_a),
        .frame_done(fd_a), .underrun(un_a)
    );

    eth_mii_tx #(.IFG_OCTETS(1)) dut_b (
        .clk(clk), .aresetn(aresetn),
        .axis_i_tready(tr_b), .axis_i_tvalid(tv_b), .axis_i_tlast(tl_b), .axis_i_tdata(td_b),
        .mii_tx_en(en_b), .mii_tx_er(er_b), .mii_txd(txd_b),
        .frame_done(fd_b), .underrun(un_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic add(input bit s, input bit tv, input bit tl, input logic [7:0] td,
                       input bit tr, input bit en, input bit er, input logic [3:0] d,
                       input bit fd, input bit un, input string nm);
        vec_t v;
        v.sel = s; v.tv = tv; v.tl = tl; v.td = td;
        v.exp = {tr, en, er, d, fd, un};
        v.nm  = nm;
        rows.push_back(v);
    endtask

    task automatic run_rows();
        foreach (rows[i]) begin
            @(negedge clk);
            if (rows[i].sel) chk(rows[i].nm, {23'd0, tr_b, en_b, er_b, txd_b, fd_b, un_b}, {23'd0, rows[i].exp});
            else             chk(rows[i].nm, {23'd0, tr_a, en_a, er_a, txd_a, fd_a, un_a}, {23'd0, rows[i].exp});
            tv_a = rows[i].sel ? 1'b0 : rows[i].tv;
            tl_a = rows[i].tl; td_a = rows[i].td;
            tv_b = rows[i].sel ? rows[i].tv : 1'b0;
            tl_b = rows[i].tl; td_b = rows[i].td;
        end
        rows.delete();
    endtask

    function automatic logic [7:0] fb(input int k);
        return 8'(k * 37 + 11);
    endfunction

    initial begin
        int en_log[400];
        logic [3:0] nib[512];
        int nn, idx, r1, f1, r2, f2, fdc, erc;
        bit acc;
        tv_a = 0; tl_a = 0; td_a = 0;
        tv_b = 0; tl_b = 0; td_b = 0;
        #1;
        chk("rst_a", {26'd0, tr_a, en_a, er_a, fd_a, un_a, txd_a == 4'd0}, 32'd1);
        chk("rst_b", {26'd0, tr_b, en_b, er_b, fd_b, un_b, txd_b == 4'd0}, 32'd1);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0, "idle_quiet");

        add(0, 1, 0, 8'h55, 1, 0, 0, 4'h0, 0, 0, "t1_idle");
        add(0, 1, 1, 8'hD5, 0, 1, 0, 4'h5, 0, 0, "t1_lo0");
        add(0, 1, 1, 8'hD5, 1, 1, 0, 4'h5, 0, 0, "t1_hi0");
        add(0, 0, 0, 8'h00, 0, 1, 0, 4'h5, 0, 0, "t1_lo1");
        add(0, 0, 0, 8'h00, 0, 1, 0, 4'hD, 0, 0, "t1_hi1");
        for (int i = 0; i < 24; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 4'h0, i == 0, 0, "t1_ifg");
        add(0, 0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0, "t1_ready");

        add(0, 1, 0, 8'hA1, 1, 0, 0, 4'h0, 0, 0, "t3_idle");
        add(0, 1, 0, 8'hB2, 0, 1, 0, 4'h1, 0, 0, "t3_lo0");
        add(0, 1, 0, 8'hB2, 1, 1, 0, 4'hA, 0, 0, "t3_hi0");
        add(0, 0, 0, 8'h00, 0, 1, 0, 4'h2, 0, 0, "t3_lo1");
        add(0, 0, 0, 8'h00, 1, 1, 0, 4'hB, 0, 0, "t3_hi1_starve");
        add(0, 0, 0, 8'h00, 0, 1, 1, 4'h0, 0, 1, "t3_err0");
        add(0, 1, 0, 8'hC3, 0, 1, 1, 4'h0, 0, 0, "t3_err1");
        add(0, 1, 0, 8'hC3, 1, 0, 0, 4'h0, 0, 0, "t3_drain0");
        add(0, 1, 1, 8'hD4, 1, 0, 0, 4'h0, 0, 0, "t3_drain1");
        for (int i = 0; i < 24; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0, "t3_ifg");
        add(0, 0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0, "t3_ready");

        add(1, 1, 1, 8'h3C, 1, 0, 0, 4'h0, 0, 0, "t5_idle0");
        add(1, 1, 1, 8'h5A, 0, 1, 0, 4'hC, 0, 0, "t5_lo0");
        add(1, 1, 1, 8'h5A, 0, 1, 0, 4'h3, 0, 0, "t5_hi0");
        add(1, 1, 1, 8'h5A, 0, 0, 0, 4'h0, 1, 0, "t5_ifg0");
        add(1, 1, 1, 8'h5A, 0, 0, 0, 4'h0, 0, 0, "t5_ifg1");
        add(1, 1, 1, 8'h5A, 1, 0, 0, 4'h0, 0, 0, "t5_idle1");
        add(1, 0, 0, 8'h00, 0, 1, 0, 4'hA, 0, 0, "t5_lo1");
        add(1, 0, 0, 8'h00, 0, 1, 0, 4'h5, 0, 0, "t5_hi1");
        add(1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 0, "t5_ifg2");
        add(1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0, "t5_ifg3");
        add(1, 0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0, "t5_idle2");
        run_rows();

        idx = 0; acc = 0; nn = 0; fdc = 0; erc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            en_log[c] = int'(en_a);
            if (en_a && nn < 512) begin nib[nn] = txd_a; nn++; end
            fdc += int'(fd_a);
            erc += int'(er_a) + int'(un_a);
            if (acc) idx++;
            tv_a = idx < 128;
            td_a = fb(idx);
            tl_a = (idx % 64) == 63;
            acc  = tr_a && tv_a;
        end
        r1 = -1; f1 = -1; r2 = -1; f2 = -1;
        for (int c = 1; c < 400; c++) begin
            if (en_log[c] == 1 && en_log[c-1] == 0) begin
                if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
            end
            if (en_log[c] == 0 && en_log[c-1] == 1) begin
                if (f1 < 0) f1 = c; else if (f2 < 0) f2 = c;
            end
        end
        chk("t2_len1", f1 - r1, 128);
        chk("t2_gap", r2 - f1, 25);
        chk("t2_len2", f2 - r2, 128);
        chk("t2_nibbles", nn, 256);
        chk("t2_frame_done", fdc, 2);
        chk("t2_no_err", erc, 0);
        for (int k = 0; k < 128 && 2 * k + 1 < nn; k++)
            chk($sformatf("t2_byte%0d", k), {24'd0, nib[2*k+1], nib[2*k]}, {24'd0, fb(k)});

        @(negedge clk);
        chk("t4_ready", {31'd0, tr_a}, 1);
        tv_a = 1; tl_a = 0; td_a = 8'h77;
        @(negedge clk);
        tv_a = 0;
        @(negedge clk);
        chk("t4_in_hi", {27'd0, en_a, txd_a}, {27'd0, 1'b1, 4'h7});
        aresetn = 1'b0;
        #1;
        chk("t4_async", {24'd0, tr_a, en_a, er_a, fd_a, un_a, 2'd0, txd_a != 4'd0}, 32'd0);
        @(negedge clk);
        chk("t4_held", {27'd0, tr_a, en_a, er_a, fd_a, un_a}, 0);
        aresetn = 1'b1;
        add(0, 1, 1, 8'h96, 1, 0, 0, 4'h0, 0, 0, "t4_idle");
        add(0, 0, 0, 8'h00, 0, 1, 0, 4'h6, 0, 0, "t4_lo");
        add(0, 0, 0, 8'h00, 0, 1, 0, 4'h9, 0, 0, "t4_hi");
        add(0, 0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 0, "t4_ifg");
        @(negedge clk);
        run_rows();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
